// File: rtl/axis_seq_divider_pkg.sv
// Shared definitions for the Kalman-filter divider handshake: FSM state type and
// saturation constants for signed quotients.
package kalman_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  function automatic logic [63:0] sat_qmax(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_qmin(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/axis_seq_divider_if.sv
// Operand/result bundle between a requester (master) and the sequential divider (slave).
interface axis_seq_divider_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;
  logic               m_axis_dout_tuser;
  logic               busy;

  modport master (
    output s_axis_dividend_tdata, s_axis_dividend_tvalid,
    output s_axis_divisor_tdata, s_axis_divisor_tvalid,
    input  m_axis_dout_tdata, m_axis_dout_tvalid, m_axis_dout_tuser, busy
  );

  modport slave (
    input  s_axis_dividend_tdata, s_axis_dividend_tvalid,
    input  s_axis_divisor_tdata, s_axis_divisor_tvalid,
    output m_axis_dout_tdata, m_axis_dout_tvalid, m_axis_dout_tuser, busy
  );
endinterface

// File: rtl/axis_seq_divider.sv
// Fixed-latency signed restoring divider: quotient truncates toward zero, remainder
// follows the dividend sign, divide-by-zero and -2^(W-1)/-1 saturate.
module axis_seq_divider
  import kalman_div_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               aclk,
  input  logic               areset,
  axis_seq_divider_if.slave  dv
);

  localparam int unsigned     CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] QMAX = WIDTH'(sat_qmax(WIDTH));
  localparam logic [WIDTH-1:0] QMIN = WIDTH'(sat_qmin(WIDTH));

  state_t             state, state_nxt;
  logic               accept;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvs;
  logic               dvd_neg, dvs_neg, dvz;
  logic [WIDTH:0]     shifted;
  logic [WIDTH+1:0]   diff;
  logic               fits;
  logic [WIDTH-1:0]   q_out, r_out;
  logic [2*WIDTH-1:0] tdata;
  logic               tvalid, tuser;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (cnt == '0) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept                = (state == IDLE) && dv.s_axis_dividend_tvalid && dv.s_axis_divisor_tvalid;
    dv.busy               = (state != IDLE);
    dv.m_axis_dout_tdata  = tdata;
    dv.m_axis_dout_tvalid = tvalid;
    dv.m_axis_dout_tuser  = tuser;
  end

  // The partial remainder stays below the divisor, so a non-borrowing difference never
  // sets bit WIDTH; testing it anyway keeps the full difference in use.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    diff    = {1'b0, shifted} - {2'b00, dvs};
    fits    = ~diff[WIDTH+1] & ~diff[WIDTH];
  end

  // With a zero divisor every step "fits", so rem ends holding |dividend| and the
  // signed remainder reproduces the dividend without a separate copy.
  always_comb begin
    r_out = dvd_neg ? -rem : rem;
    if (dvz)
      q_out = dvd_neg ? QMIN : QMAX;
    else if (!(dvd_neg ^ dvs_neg) && quo[WIDTH-1])
      q_out = QMAX;
    else
      q_out = (dvd_neg ^ dvs_neg) ? -quo : quo;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      dvd_neg <= 1'b0;
      dvs_neg <= 1'b0;
      dvz     <= 1'b0;
      tdata   <= '0;
      tuser   <= 1'b0;
      tvalid  <= 1'b0;
    end else begin
      tvalid <= (state == SIGN);
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_neg <= dv.s_axis_dividend_tdata[WIDTH-1];
            dvs_neg <= dv.s_axis_divisor_tdata[WIDTH-1];
            quo     <= dv.s_axis_dividend_tdata[WIDTH-1] ? -dv.s_axis_dividend_tdata
                                                         : dv.s_axis_dividend_tdata;
            dvs     <= dv.s_axis_divisor_tdata[WIDTH-1] ? -dv.s_axis_divisor_tdata
                                                        : dv.s_axis_divisor_tdata;
            dvz     <= (dv.s_axis_divisor_tdata == '0);
            rem     <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
          end
        end
        CALC: begin
          rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], fits};
          cnt <= cnt - 1'b1;
        end
        SIGN: begin
          tdata <= {q_out, r_out};
          tuser <= dvz;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_seq_divider.sv
// Directed and randomized checks of axis_seq_divider against an arithmetic reference.
module tb_axis_seq_divider;
  localparam int unsigned W = 16;

  logic        aclk = 1'b0;
  logic        areset;
  int unsigned ncmp = 0;
  int unsigned nerr = 0;

  axis_seq_divider_if #(.WIDTH(W)) dv ();

  axis_seq_divider #(.WIDTH(W)) dut (
    .aclk   (aclk),
    .areset (areset),
    .dv     (dv)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {tuser, quotient, remainder} from plain integer division rules.
  function automatic logic [32:0] ref_div(input int a, input int b);
    int   q, r;
    logic z;
    z = (b == 0);
    if (z) begin
      q = (a >= 0) ? 32767 : -32768;
      r = a;
    end else if (a == -32768 && b == -1) begin
      q = 32767;
      r = 0;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {z, q[15:0], r[15:0]};
  endfunction

  task automatic set_ops(input int a, input int b);
    dv.s_axis_dividend_tdata = a[15:0];
    dv.s_axis_divisor_tdata  = b[15:0];
  endtask

  task automatic run_op(input int a, input int b, input logic [32:0] exp, input string tag);
    logic [17:0] tv, bz;
    set_ops(a, b);
    dv.s_axis_dividend_tvalid = 1'b1;
    dv.s_axis_divisor_tvalid  = 1'b1;
    for (int k = 0; k < 18; k++) begin
      @(posedge aclk); #1;
      if (k == 0) begin
        dv.s_axis_dividend_tvalid = 1'b0;
        dv.s_axis_divisor_tvalid  = 1'b0;
      end
      tv[k] = dv.m_axis_dout_tvalid;
      bz[k] = dv.busy;
      if (k == 17)
        check($sformatf("%s result", tag), {dv.m_axis_dout_tuser, dv.m_axis_dout_tdata}, exp);
    end
    check($sformatf("%s tvalid pattern", tag), tv, 18'h20000);
    check($sformatf("%s busy pattern", tag), bz, 18'h1FFFF);
    @(posedge aclk); #1;
    check($sformatf("%s hold", tag),
          {dv.m_axis_dout_tvalid, dv.m_axis_dout_tuser, dv.m_axis_dout_tdata}, {1'b0, exp});
  endtask

  initial begin
    logic [35:0] tv36;
    logic        seen;
    logic [15:0] ra, rb;
    int          a, b;

    areset = 1'b1;
    dv.s_axis_dividend_tdata  = '0;
    dv.s_axis_divisor_tdata   = '0;
    dv.s_axis_dividend_tvalid = 1'b0;
    dv.s_axis_divisor_tvalid  = 1'b0;
    #21;
    areset = 1'b0;
    check("reset outputs",
          {dv.busy, dv.m_axis_dout_tvalid, dv.m_axis_dout_tuser, dv.m_axis_dout_tdata}, 35'h0);

    run_op( 100,  7, 33'h0_000E_0002, "100/7");
    run_op(-100,  7, 33'h0_FFF2_FFFE, "-100/7");
    run_op( 100, -7, 33'h0_FFF2_0002, "100/-7");
    run_op(-100, -7, 33'h0_000E_FFFE, "-100/-7");
    run_op( 100,  0, 33'h1_7FFF_0064, "100/0");
    run_op(  -5,  0, 33'h1_8000_FFFB, "-5/0");
    run_op(-32768, -1, 33'h0_7FFF_0000, "ovf");
    run_op(-32768,  1, 33'h0_8000_0000, "-32768/1");

    // Both tvalids held high across a completion.
    set_ops(5, 2);
    dv.s_axis_dividend_tvalid = 1'b1;
    dv.s_axis_divisor_tvalid  = 1'b1;
    for (int k = 0; k < 36; k++) begin
      @(posedge aclk); #1;
      if (k == 4) set_ops(9, 3);
      tv36[k] = dv.m_axis_dout_tvalid;
      if (k == 17) check("sustain first", dv.m_axis_dout_tdata, 32'h0002_0001);
      if (k == 18) check("sustain held+busy", {dv.busy, dv.m_axis_dout_tdata}, {1'b1, 32'h0002_0001});
      if (k == 35) check("sustain second", dv.m_axis_dout_tdata, 32'h0003_0000);
    end
    dv.s_axis_dividend_tvalid = 1'b0;
    dv.s_axis_divisor_tvalid  = 1'b0;
    check("sustain tvalid pattern", tv36, 36'h8_0002_0000);

    // Only the dividend is valid: nothing may be accepted.
    @(posedge aclk); #1;
    dv.s_axis_dividend_tvalid = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge aclk); #1;
      seen = seen | dv.busy | dv.m_axis_dout_tvalid;
    end
    dv.s_axis_dividend_tvalid = 1'b0;
    check("one tvalid no accept", seen, 1'b0);

    // Reset in the middle of an operation.
    set_ops(1000, 3);
    dv.s_axis_dividend_tvalid = 1'b1;
    dv.s_axis_divisor_tvalid  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge aclk); #1;
      if (k == 0) begin
        dv.s_axis_dividend_tvalid = 1'b0;
        dv.s_axis_divisor_tvalid  = 1'b0;
      end
    end
    check("busy before abort", dv.busy, 1'b1);
    areset = 1'b1;
    #1;
    check("abort outputs",
          {dv.busy, dv.m_axis_dout_tvalid, dv.m_axis_dout_tuser, dv.m_axis_dout_tdata}, 35'h0);
    #2;
    areset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge aclk); #1;
      seen = seen | dv.m_axis_dout_tvalid;
    end
    check("no tvalid after abort", seen, 1'b0);
    run_op(1000, 3, 33'h0_014D_0001, "1000/3");

    // Randomized operands, with extra weight on zero divisors and the most negative dividend.
    for (int i = 0; i < 30; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 5) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = 16'h8000;
      if ($urandom_range(0, 3) == 0) rb = 16'($signed(4'($urandom)));
      a = $signed(ra);
      b = $signed(rb);
      run_op(a, b, ref_div(a, b), $sformatf("rand%0d %0d/%0d", i, a, b));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/axis_seq_divider.md
# axis_seq_divider

Sequential signed integer divider with an AXI-stream-style, tready-less interface. It is the responder side of the divider handshake used by the Kalman filter matrix blocks, such as the 2x2 inverter, and replaces the vendor divider core with portable RTL. It accepts one dividend/divisor pair when idle and returns a quotient and remainder after a fixed latency. Results stay held on the output until the next result is produced.

## Interface
- WIDTH, 16, operand width in bits; operands are two's complement.
- aclk  in  1  clock, rising edge.
- areset  in  1  reset; asynchronous, active-high.
- s_axis_dividend_tdata  in  WIDTH  dividend.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_divisor_tdata  in  WIDTH  divisor.
- s_axis_divisor_tvalid  in  1  divisor valid.
- m_axis_dout_tdata  out  2*WIDTH  {quotient[2W-1:W], remainder[W-1:0]}.
- m_axis_dout_tvalid  out  1  one-cycle result strobe.
- m_axis_dout_tuser  out  1  divide-by-zero flag for the current tdata.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, CALC, SIGN.
- IDLE -> CALC: taken when both tvalids are high at an edge (accept). On accept, latch |dividend|, |divisor|, both sign bits and a zero-divisor flag, and set the iteration counter to WIDTH-1.
- No tready. Inputs arriving while in CALC or SIGN are ignored and dropped. If only one tvalid is high, nothing is accepted.
- CALC: one restoring radix-2 step per cycle on WIDTH+1-bit magnitudes. The counter decrements each cycle; when the counter is 0, go to SIGN.
- SIGN -> IDLE, unconditional. In SIGN, register tdata and tuser, and set tvalid for one cycle.
- Quotient sign rules:
  - Quotient truncates toward zero and is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Invariant: dividend = q*divisor + r.
- Divisor = 0:
  - Quotient = 0x7FF…F if dividend >= 0, otherwise 0x80…0.
  - Remainder = dividend; tuser = 1.
  - The full CALC latency still elapses.
- Overflow, (-2^(W-1)) / -1: quotient saturates to 0x7FF…F, remainder = 0, tuser = 0.
- tdata and tuser hold their values between results. Only a new SIGN state updates them.
- Sustained tvalid: if tvalid stays high across a completion, a new accept happens in the IDLE cycle where tvalid=1 is showing the previous result. This is legal; that previous result stays valid for that cycle.

## Timing
- Accept at edge 0. Result appears at edge WIDTH+1 (edge 17 for WIDTH=16). m_axis_dout_tvalid is high for exactly one cycle after that edge.
- Fixed latency regardless of operand values, including divide-by-zero and overflow.
- Throughput: one operation per WIDTH+2 cycles at most.
- Reset values: state IDLE, tdata 0, tvalid 0, tuser 0, busy 0, all internal registers 0.
- Reset mid-operation: abort immediately. No tvalid is issued for the aborted operation, and tdata returns to 0.
- The first accept is possible at the first edge after reset deasserts.

## Structure
- Shared package kalman_div_pkg holds:
  - the state enum (IDLE/CALC/SIGN);
  - the function used to compute the saturation constants QMAX/QMIN from WIDTH.
- Single module. No sub-module: the datapath is one subtract/compare with a shift register, and a separate block adds no reuse.

## Test plan
- 100 / 7 -> tdata 0x000E_0002, tuser 0. tvalid high only in the cycle after edge 17; busy high for edges 0-17.
- -100 / 7 -> 0xFFF2_FFFE. 100 / -7 -> 0xFFF2_0002. -100 / -7 -> 0x000E_FFFE.
- 100 / 0 -> 0x7FFF_0064, tuser 1. -5 / 0 -> 0x8000_FFFB, tuser 1. -32768 / -1 -> 0x7FFF_0000, tuser 0.
- Both tvalids held high continuously:
  - 5 / 2 is accepted at edge 0.
  - Operands change to 9 / 3 at edge 4 (while busy).
  - Result 0x0002_0001 appears at edge 17.
  - 9 / 3 is accepted at edge 18 and returns 0x0003_0000 at edge 35. The first result is held in tdata until then.
- Only dividend_tvalid high for 20 cycles -> no accept, busy stays 0, tvalid stays 0.
- areset pulsed at edge 8 of 1000 / 3 -> no tvalid, tdata 0. A following 1000 / 3 returns 0x014D_0001.
